// File: rtl/vx_data_access_pipe.sv
// vx_data_access_pipe
//   Per-bank cache data store. Multi-port word reads and byte-enabled word writes go to a
//   line-wide single-port array. Read results return on a registered valid/ready channel.
//   Line fills arrive as FILL_BEATS narrow beats. They are assembled in a line buffer and
//   written to the array in a single COMMIT cycle.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*                  request channel (valid/ready, rw, line, per-port pmask/wsel/byteen/wdata, tag)
//   fill_*                 fill beat channel (valid/ready, line sampled on beat 0, beat data)
//   rsp_*                  read response channel (valid/ready, per-port data, echoed pmask/tag)
//   rsp_perr_o             byte parity error on an active port (parity build only, else 0)
//   busy_o                 fill in progress
//
// Optional feature: define VX_DATA_PARITY_EN to store one even-parity bit per byte and
// flag mismatches on reads through rsp_perr_o.
module vx_data_access_pipe #(
  parameter int unsigned CACHE_SIZE      = 4096,
  parameter int unsigned CACHE_LINE_SIZE = 64,
  parameter int unsigned NUM_BANKS       = 1,
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned WORD_SIZE       = 4,
  parameter int unsigned WRITE_ENABLE    = 1,
  parameter int unsigned FILL_BEATS      = 4,
  parameter int unsigned TAG_WIDTH       = 8,
  localparam int unsigned LINES      = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
  localparam int unsigned LSB        = (LINES > 1) ? $clog2(LINES) : 1,
  localparam int unsigned WPL        = CACHE_LINE_SIZE / WORD_SIZE,
  localparam int unsigned WSB        = (WPL > 1) ? $clog2(WPL) : 1,
  localparam int unsigned LINE_BITS  = CACHE_LINE_SIZE * 8,
  localparam int unsigned WORD_BITS  = WORD_SIZE * 8,
  localparam int unsigned BW         = LINE_BITS / FILL_BEATS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_rw_i,
  input  logic [LSB-1:0]                 req_line_i,
  input  logic [NUM_PORTS-1:0]           req_pmask_i,
  input  logic [NUM_PORTS*WSB-1:0]       req_wsel_i,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] req_byteen_i,
  input  logic [NUM_PORTS*WORD_BITS-1:0] req_wdata_i,
  input  logic [TAG_WIDTH-1:0]           req_tag_i,
  input  logic                           fill_valid_i,
  output logic                           fill_ready_o,
  input  logic [LSB-1:0]                 fill_line_i,
  input  logic [BW-1:0]                  fill_data_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [NUM_PORTS*WORD_BITS-1:0] rsp_data_o,
  output logic [NUM_PORTS-1:0]           rsp_pmask_o,
  output logic [TAG_WIDTH-1:0]           rsp_tag_o,
  output logic                           rsp_perr_o,
  output logic                           busy_o
);

  localparam int unsigned LINE_BYTES = CACHE_LINE_SIZE;
  localparam int unsigned CW         = (FILL_BEATS > 1) ? $clog2(FILL_BEATS) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(FILL_BEATS - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StCommit  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LSB-1:0]       fill_line_q;
  logic [LINE_BITS-1:0] fill_buf_q;

  logic [LINE_BITS-1:0] mem_q [LINES];
  logic [LINE_BITS-1:0] rd_line_q;

  logic                     rsp_valid_q;
  logic [TAG_WIDTH-1:0]     rsp_tag_q;
  logic [NUM_PORTS-1:0]     rsp_pmask_q;
  logic [NUM_PORTS*WSB-1:0] rsp_wsel_q;

  logic                  req_fire, rd_fire, wr_fire, fill_fire;
  logic [LINE_BYTES-1:0] mem_we;
  logic [LINE_BITS-1:0]  mem_wdata;
  logic [LSB-1:0]        mem_waddr;

  assign fill_ready_o = (state_q != StCommit);
  assign req_ready_o  = (state_q != StCommit) && (!rsp_valid_q || rsp_ready_i);
  assign busy_o       = (state_q != StIdle);

  assign fill_fire = fill_valid_i && fill_ready_o;
  assign req_fire  = req_valid_i && req_ready_o;
  assign rd_fire   = req_fire && !req_rw_i;
  assign wr_fire   = req_fire && req_rw_i;

  // Fill FSM and beat counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fill_fire) state_d = (FILL_BEATS == 1) ? StCommit : StCollect;
      end
      StCollect: begin
        if (fill_fire && (cnt_q == CntLast)) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (fill_fire) cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fill_line_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fill_fire && (state_q == StIdle)) fill_line_q <= fill_line_i;
    end
  end

  // Line buffer is pure datapath; a reset mid-fill restarts the counter, so stale beats are
  // always overwritten before the next commit.
  always_ff @(posedge clk_i) begin
    if (fill_fire) fill_buf_q[int'(cnt_q)*BW +: BW] <= fill_data_i;
  end

  // Array write port: a commit owns the whole line. Requests are blocked during COMMIT, so
  // the two never collide. Ports are visited in ascending order, so the higher port wins a
  // shared byte.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    mem_we    = '0;
    mem_wdata = '0;
    mem_waddr = req_line_i;
    if (state_q == StCommit) begin
      mem_waddr = fill_line_q;
      mem_we    = '1;
      mem_wdata = fill_buf_q;
    end else if (wr_fire && (WRITE_ENABLE != 0)) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_pmask_i[p]) begin
          for (int b = 0; b < WORD_SIZE; b++) begin
            if (req_byteen_i[p*WORD_SIZE+b]) begin
              idx = int'(req_wsel_i[p*WSB +: WSB]) * WORD_SIZE + b;
              mem_we[idx] = 1'b1;
              mem_wdata[idx*8 +: 8] = req_wdata_i[(p*WORD_SIZE+b)*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Array contents and read register are not reset. The read register moves only on reads.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (mem_we[b]) mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (rd_fire) rd_line_q <= mem_q[req_line_i];
  end

  // Response control
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_pmask_q <= '0;
      rsp_wsel_q  <= '0;
    end else begin
      if (rd_fire) begin
        rsp_valid_q <= 1'b1;
        rsp_tag_q   <= req_tag_i;
        rsp_pmask_q <= req_pmask_i;
        rsp_wsel_q  <= req_wsel_i;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Word extraction happens after the register, so the payload stays stable under backpressure.
  always_comb begin
    rsp_data_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsp_valid_q && rsp_pmask_q[p]) begin
        rsp_data_o[p*WORD_BITS +: WORD_BITS] =
          rd_line_q[int'(rsp_wsel_q[p*WSB +: WSB])*WORD_BITS +: WORD_BITS];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_pmask_o = rsp_pmask_q;

`ifdef VX_DATA_PARITY_EN
  logic [LINE_BYTES-1:0] par_q [LINES];
  logic                  perr_d, perr_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (mem_we[b]) par_q[mem_waddr][b] <= ^mem_wdata[b*8 +: 8];
    end
  end

  // Check against the array at acceptance, in the same cycle the data is sampled
  always_comb begin
    int unsigned idx;
    idx    = 0;
    perr_d = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (req_pmask_i[p]) begin
        for (int b = 0; b < WORD_SIZE; b++) begin
          idx = int'(req_wsel_i[p*WSB +: WSB]) * WORD_SIZE + b;
          if ((^mem_q[req_line_i][idx*8 +: 8]) != par_q[req_line_i][idx]) perr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perr_q <= 1'b0;
    end else if (rd_fire) begin
      perr_q <= perr_d;
    end
  end

  assign rsp_perr_o = rsp_valid_q && perr_q;
`else
  assign rsp_perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_vx_data_access_pipe.sv
module tb_vx_data_access_pipe;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid, req_rw, fill_valid, rsp_ready;
  logic [5:0]   req_line, fill_line;
  logic [1:0]   req_pmask;
  logic [7:0]   req_wsel, req_byteen, req_tag;
  logic [63:0]  req_wdata;
  logic [127:0] fill_data;

  logic        req_ready, fill_ready, rsp_valid, rsp_perr, busy;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_pmask;
  logic [7:0]  rsp_tag;

  logic        ro_req_ready, ro_fill_ready, ro_rsp_valid, ro_rsp_perr, ro_busy;
  logic [63:0] ro_rsp_data;
  logic [1:0]  ro_rsp_pmask;
  logic [7:0]  ro_rsp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  vx_data_access_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_line_i(req_line), .req_pmask_i(req_pmask), .req_wsel_i(req_wsel),
    .req_byteen_i(req_byteen), .req_wdata_i(req_wdata), .req_tag_i(req_tag),
    .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_line_i(fill_line),
    .fill_data_i(fill_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_pmask_o(rsp_pmask), .rsp_tag_o(rsp_tag), .rsp_perr_o(rsp_perr), .busy_o(busy)
  );

  // Read-only build driven by the same stimulus
  vx_data_access_pipe #(.WRITE_ENABLE(0)) dut_ro (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(ro_req_ready), .req_rw_i(req_rw),
    .req_line_i(req_line), .req_pmask_i(req_pmask), .req_wsel_i(req_wsel),
    .req_byteen_i(req_byteen), .req_wdata_i(req_wdata), .req_tag_i(req_tag),
    .fill_valid_i(fill_valid), .fill_ready_o(ro_fill_ready), .fill_line_i(fill_line),
    .fill_data_i(fill_data),
    .rsp_valid_o(ro_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(ro_rsp_data),
    .rsp_pmask_o(ro_rsp_pmask), .rsp_tag_o(ro_rsp_tag), .rsp_perr_o(ro_rsp_perr),
    .busy_o(ro_busy)
  );

  typedef struct {
    logic        rw;
    logic [1:0]  pmask;
    logic [3:0]  ws0, ws1, be0, be1;
    logic [31:0] wd0, wd1;
    logic [31:0] e0, e1;   // expected words, writable build
    logic [31:0] r0, r1;   // expected words, read-only build
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic rw, input logic [5:0] line, input logic [1:0] pm,
                         input logic [3:0] ws0, input logic [3:0] ws1,
                         input logic [3:0] be0, input logic [3:0] be1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [7:0] tag);
    req_valid  = 1'b1;
    req_rw     = rw;
    req_line   = line;
    req_pmask  = pm;
    req_wsel   = {ws1, ws0};
    req_byteen = {be1, be0};
    req_wdata  = {wd1, wd0};
    req_tag    = tag;
  endtask

  task automatic fill_beat(input logic [5:0] line, input logic [7:0] b);
    fill_valid = 1'b1;
    fill_line  = line;
    fill_data  = {16{b}};
    step();
  endtask

  initial begin
    //          rw    pm     ws0 ws1 be0    be1    wd0           wd1           e0            e1            r0            r1
    tbl[0] = '{1'b1, 2'b01, 3,  3,  4'h3,  4'hF,  32'hAABBCCDD, 32'hDEADBEEF, 0,            0,            0,            0};
    tbl[1] = '{1'b0, 2'b11, 3,  0,  4'h0,  4'h0,  0,            0,            32'h1111CCDD, 32'h11111111, 32'h11111111, 32'h11111111};
    tbl[2] = '{1'b1, 2'b11, 2,  2,  4'hF,  4'hF,  32'h01010101, 32'h02020202, 0,            0,            0,            0};
    tbl[3] = '{1'b0, 2'b11, 2,  3,  4'h0,  4'h0,  0,            0,            32'h02020202, 32'h1111CCDD, 32'h11111111, 32'h11111111};
    tbl[4] = '{1'b0, 2'b10, 2,  2,  4'h0,  4'h0,  0,            0,            0,            32'h02020202, 0,            32'h11111111};
    tbl[5] = '{1'b1, 2'b11, 4,  4,  4'h5,  4'hC,  32'hA0A1A2A3, 32'hB0B1B2B3, 0,            0,            0,            0};
    tbl[6] = '{1'b0, 2'b11, 4,  15, 4'h0,  4'h0,  0,            0,            32'hB0B122A3, 32'h44444444, 32'h22222222, 32'h44444444};
    tbl[7] = '{1'b0, 2'b00, 4,  15, 4'h0,  4'h0,  0,            0,            0,            0,            0,            0};

    rst_ni = 1'b0;
    req_valid = 0; req_rw = 0; req_line = 0; req_pmask = 0; req_wsel = 0;
    req_byteen = 0; req_wdata = 0; req_tag = 0;
    fill_valid = 0; fill_line = 0; fill_data = 0; rsp_ready = 1;
    step();
    step();
    rst_ni = 1'b1;
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_tag", rsp_tag, 0);
    chk("reset rsp_pmask", rsp_pmask, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset req_ready", req_ready, 1);
    chk("reset fill_ready", fill_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset perr", rsp_perr, 0);

    // Fill line 5
    fill_beat(6'd5, 8'h11);
    chk("fill beat0 busy", busy, 1);
    fill_beat(6'd5, 8'h22);
    fill_beat(6'd5, 8'h33);
    chk("fill beat2 busy", busy, 1);
    fill_beat(6'd5, 8'h44);
    chk("commit busy", busy, 1);
    chk("commit req_ready", req_ready, 0);
    chk("commit fill_ready", fill_ready, 0);
    fill_valid = 1'b0;
    step();
    chk("after commit busy", busy, 0);
    chk("after commit req_ready", req_ready, 1);

    set_req(1'b0, 6'd5, 2'b11, 4'd0, 4'd15, 4'h0, 4'h0, 0, 0, 8'h21);
    step();
    req_valid = 1'b0;
    chk("fill read valid", rsp_valid, 1);
    chk("fill read data", rsp_data, 64'h44444444_11111111);
    chk("fill read tag", rsp_tag, 8'h21);
    chk("fill read perr", rsp_perr, 0);
    step();
    chk("rsp drained", rsp_valid, 0);

    // Back-to-back vector table
    for (int i = 0; i < 8; i++) begin
      set_req(tbl[i].rw, 6'd5, tbl[i].pmask, tbl[i].ws0, tbl[i].ws1, tbl[i].be0, tbl[i].be1,
              tbl[i].wd0, tbl[i].wd1, 8'h40 + 8'(i));
      step();
      if (tbl[i].rw) begin
        chk($sformatf("vec%0d write no rsp", i), rsp_valid, 0);
      end else begin
        chk($sformatf("vec%0d valid", i), rsp_valid, 1);
        chk($sformatf("vec%0d data", i), rsp_data, {tbl[i].e1, tbl[i].e0});
        chk($sformatf("vec%0d ro data", i), ro_rsp_data, {tbl[i].r1, tbl[i].r0});
        chk($sformatf("vec%0d pmask", i), rsp_pmask, tbl[i].pmask);
        chk($sformatf("vec%0d tag", i), rsp_tag, 8'h40 + 8'(i));
      end
    end
    req_valid = 1'b0;
    step();

    // Backpressure: response held, next read stalls until release
    set_req(1'b0, 6'd5, 2'b11, 4'd0, 4'd15, 4'h0, 4'h0, 0, 0, 8'hA5);
    rsp_ready = 1'b0;
    step();
    set_req(1'b0, 6'd5, 2'b11, 4'd15, 4'd0, 4'h0, 4'h0, 0, 0, 8'h5A);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d data", c), rsp_data, 64'h44444444_11111111);
      chk($sformatf("bp%0d tag", c), rsp_tag, 8'hA5);
      chk($sformatf("bp%0d req_ready", c), req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp release req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("bp next valid", rsp_valid, 1);
    chk("bp next tag", rsp_tag, 8'h5A);
    chk("bp next data", rsp_data, 64'h11111111_44444444);
    step();
    chk("bp drained", rsp_valid, 0);

    // Reset in the middle of a fill, then refill line 7
    fill_beat(6'd7, 8'hAA);
    fill_beat(6'd7, 8'hBB);
    chk("midfill busy", busy, 1);
    fill_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("reset busy immediate", busy, 0);
    chk("reset fill_ready", fill_ready, 1);
    step();
    rst_ni = 1'b1;
    step();
    fill_beat(6'd7, 8'hC1);
    fill_beat(6'd7, 8'hC2);
    fill_beat(6'd7, 8'hC3);
    fill_beat(6'd7, 8'hC4);
    fill_valid = 1'b0;
    step();
    set_req(1'b0, 6'd7, 2'b11, 4'd0, 4'd13, 4'h0, 4'h0, 0, 0, 8'h77);
    step();
    chk("refill data", rsp_data, 64'hC4C4C4C4_C1C1C1C1);
    set_req(1'b0, 6'd7, 2'b11, 4'd4, 4'd11, 4'h0, 4'h0, 0, 0, 8'h78);
    step();
    chk("refill mid data", rsp_data, 64'hC3C3C3C3_C2C2C2C2);
    set_req(1'b0, 6'd5, 2'b11, 4'd4, 4'd3, 4'h0, 4'h0, 0, 0, 8'h79);
    step();
    req_valid = 1'b0;
    chk("line5 kept data", rsp_data, 64'h1111CCDD_B0B122A3);
    chk("line5 kept ro data", ro_rsp_data, 64'h11111111_22222222);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
